ula_sequenciador: RTL and testbench

ULA_SEQUENCIADOR -- requirements
Module: ula_sequenciador

---
 rtl/ula_sequenciador.sv | 107 ++++++++++
 tb/tb_ula_sequenciador.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// Handshake sequencer around a combinational ALU: latches a request, captures the ALU
// result after one execute cycle, and holds it until the consumer takes it.
module ula_sequenciador #(
  parameter int unsigned LARGURA_CONT = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Ent_Valido,
  output logic                    Ent_Pronto,
  input  logic [5:0]              Ent_A,
  input  logic [5:0]              Ent_B,
  input  logic [3:0]              Ent_Sel,
  output logic [5:0]              ULA_A,
  output logic [5:0]              ULA_B,
  output logic [3:0]              ULA_Sel,
  output logic                    ULA_Reset,
  input  logic [5:0]              ULA_O,
  input  logic                    ULA_Overflow,
  input  logic                    ULA_Zero,
  output logic                    Sai_Valido,
  input  logic                    Sai_Pronto,
  output logic [5:0]              Sai_O,
  output logic                    Sai_Overflow,
  output logic                    Sai_Zero,
  output logic                    Ovf_Acumulado,
  input  logic                    Limpa_Ovf,
  output logic [LARGURA_CONT-1:0] Contagem
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESULTADO} estado_t;

  localparam logic [LARGURA_CONT-1:0] Um = {{(LARGURA_CONT-1){1'b0}}, 1'b1};

  estado_t                 estado_q;
  logic [5:0]              op_a_q;
  logic [5:0]              op_b_q;
  logic [3:0]              op_sel_q;
  logic [5:0]              sai_o_q;
  logic                    sai_ovf_q;
  logic                    sai_zero_q;
  logic                    sai_valido_q;
  logic                    ent_pronto_q;
  logic                    ovf_acc_q;
  logic [LARGURA_CONT-1:0] contagem_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q     <= OCIOSO;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      sai_o_q      <= '0;
      sai_ovf_q    <= 1'b0;
      sai_zero_q   <= 1'b0;
      sai_valido_q <= 1'b0;
      ent_pronto_q <= 1'b0;
      ovf_acc_q    <= 1'b0;
      contagem_q   <= '0;
    end else begin
      // A capture in EXECUTA below overrides this clear when both hit the same edge.
      if (Limpa_Ovf) ovf_acc_q <= 1'b0;
      unique case (estado_q)
        OCIOSO: begin
          if (Ent_Valido && ent_pronto_q) begin
            op_a_q       <= Ent_A;
            op_b_q       <= Ent_B;
            op_sel_q     <= Ent_Sel;
            ent_pronto_q <= 1'b0;
            estado_q     <= EXECUTA;
          end else begin
            ent_pronto_q <= 1'b1;
          end
        end
        EXECUTA: begin
          sai_o_q      <= ULA_O;
          sai_ovf_q    <= ULA_Overflow;
          sai_zero_q   <= ULA_Zero;
          if (ULA_Overflow) ovf_acc_q <= 1'b1;
          sai_valido_q <= 1'b1;
          estado_q     <= RESULTADO;
        end
        RESULTADO: begin
          if (Sai_Pronto) begin
            sai_valido_q <= 1'b0;
            ent_pronto_q <= 1'b1;
            contagem_q   <= contagem_q + Um;
            estado_q     <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign Ent_Pronto    = ent_pronto_q;
  assign ULA_A         = op_a_q;
  assign ULA_B         = op_b_q;
  assign ULA_Sel       = op_sel_q;
  assign ULA_Reset     = ~Reset;
  assign Sai_Valido    = sai_valido_q;
  assign Sai_O         = sai_o_q;
  assign Sai_Overflow  = sai_ovf_q;
  assign Sai_Zero      = sai_zero_q;
  assign Ovf_Acumulado = ovf_acc_q;
  assign Contagem      = contagem_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a small combinational ALU stub
// (sel 0000 = add with carry-out as overflow, sel 1000 = AND).
module tb_ula_sequenciador;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Ent_Valido;
  logic       Ent_Pronto;
  logic [5:0] Ent_A;
  logic [5:0] Ent_B;
  logic [3:0] Ent_Sel;
  logic [5:0] ULA_A;
  logic [5:0] ULA_B;
  logic [3:0] ULA_Sel;
  logic       ULA_Reset;
  logic [5:0] ULA_O;
  logic       ULA_Overflow;
  logic       ULA_Zero;
  logic       Sai_Valido;
  logic       Sai_Pronto;
  logic [5:0] Sai_O;
  logic       Sai_Overflow;
  logic       Sai_Zero;
  logic       Ovf_Acumulado;
  logic       Limpa_Ovf;
  logic [7:0] Contagem;

  int tests = 0;
  int failed = 0;

  always #5 Clock = ~Clock;

  ula_sequenciador #(.LARGURA_CONT(8)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Ent_Valido    (Ent_Valido),
    .Ent_Pronto    (Ent_Pronto),
    .Ent_A         (Ent_A),
    .Ent_B         (Ent_B),
    .Ent_Sel       (Ent_Sel),
    .ULA_A         (ULA_A),
    .ULA_B         (ULA_B),
    .ULA_Sel       (ULA_Sel),
    .ULA_Reset     (ULA_Reset),
    .ULA_O         (ULA_O),
    .ULA_Overflow  (ULA_Overflow),
    .ULA_Zero      (ULA_Zero),
    .Sai_Valido    (Sai_Valido),
    .Sai_Pronto    (Sai_Pronto),
    .Sai_O         (Sai_O),
    .Sai_Overflow  (Sai_Overflow),
    .Sai_Zero      (Sai_Zero),
    .Ovf_Acumulado (Ovf_Acumulado),
    .Limpa_Ovf     (Limpa_Ovf),
    .Contagem      (Contagem)
  );

  logic [6:0] soma;
  always_comb begin
    soma         = {1'b0, ULA_A} + {1'b0, ULA_B};
    ULA_O        = 6'd0;
    ULA_Overflow = 1'b0;
    case (ULA_Sel)
      4'b0000: begin
        ULA_O        = soma[5:0];
        ULA_Overflow = soma[6];
      end
      4'b1000: ULA_O = ULA_A & ULA_B;
      default: ULA_O = 6'd0;
    endcase
    ULA_Zero = (ULA_O == 6'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [3:0] sel);
    Ent_A = a; Ent_B = b; Ent_Sel = sel; Ent_Valido = 1'b1;
    tick();
    Ent_Valido = 1'b0;
    tick();
    Sai_Pronto = 1'b1;
    tick();
    Sai_Pronto = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Ent_Valido = 1'b0; Ent_A = 6'd0; Ent_B = 6'd0; Ent_Sel = 4'd0;
    Sai_Pronto = 1'b0; Limpa_Ovf = 1'b0;
    tick();
    tick();
    chk("rst_ent_pronto", 32'(Ent_Pronto), 0);
    chk("rst_ula_reset", 32'(ULA_Reset), 1);
    chk("rst_sai_valido", 32'(Sai_Valido), 0);
    chk("rst_contagem", 32'(Contagem), 0);
    chk("rst_ovf", 32'(Ovf_Acumulado), 0);

    Reset = 1'b1;
    #1;
    chk("rel_ula_reset", 32'(ULA_Reset), 0);
    tick();
    chk("rel_ent_pronto", 32'(Ent_Pronto), 1);

    // Basic add: 5 + 3 = 8
    Ent_A = 6'd5; Ent_B = 6'd3; Ent_Sel = 4'b0000; Ent_Valido = 1'b1;
    tick();
    Ent_Valido = 1'b0;
    chk("basic_ula_a", 32'(ULA_A), 5);
    chk("basic_ula_b", 32'(ULA_B), 3);
    chk("basic_ula_sel", 32'(ULA_Sel), 0);
    chk("basic_pronto_busy", 32'(Ent_Pronto), 0);
    chk("basic_valido_early", 32'(Sai_Valido), 0);
    tick();
    chk("basic_valido", 32'(Sai_Valido), 1);
    chk("basic_sai_o", 32'(Sai_O), 8);
    chk("basic_ovf", 32'(Sai_Overflow), 0);
    chk("basic_zero", 32'(Sai_Zero), 0);
    Sai_Pronto = 1'b1;
    tick();
    Sai_Pronto = 1'b0;
    chk("basic_valido_drop", 32'(Sai_Valido), 0);
    chk("basic_contagem", 32'(Contagem), 1);
    chk("basic_pronto_back", 32'(Ent_Pronto), 1);

    // Backpressure: 10 + 7 = 17 held while new requests are presented
    Ent_A = 6'd10; Ent_B = 6'd7; Ent_Sel = 4'b0000; Ent_Valido = 1'b1;
    tick();
    tick();
    Ent_A = 6'd1; Ent_B = 6'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_sai_o", 32'(Sai_O), 17);
      chk("bp_valido", 32'(Sai_Valido), 1);
      chk("bp_ent_pronto", 32'(Ent_Pronto), 0);
      chk("bp_ula_a", 32'(ULA_A), 10);
    end
    Ent_Valido = 1'b0;
    Sai_Pronto = 1'b1;
    tick();
    Sai_Pronto = 1'b0;
    chk("bp_contagem", 32'(Contagem), 2);
    chk("bp_ula_a_after", 32'(ULA_A), 10);

    // Sticky overflow: 40 + 30 = 70 -> 6 with carry
    Ent_A = 6'd40; Ent_B = 6'd30; Ent_Sel = 4'b0000; Ent_Valido = 1'b1;
    tick();
    Ent_Valido = 1'b0;
    tick();
    chk("ovf_sai_o", 32'(Sai_O), 6);
    chk("ovf_sai_ovf", 32'(Sai_Overflow), 1);
    chk("ovf_acc_set", 32'(Ovf_Acumulado), 1);
    Sai_Pronto = 1'b1;
    tick();
    Sai_Pronto = 1'b0;
    run_op(6'd1, 6'd2, 4'b0000);
    chk("ovf_next_sai_o", 32'(Sai_O), 3);
    chk("ovf_next_sai_ovf", 32'(Sai_Overflow), 0);
    chk("ovf_acc_persist", 32'(Ovf_Acumulado), 1);
    Limpa_Ovf = 1'b1;
    tick();
    Limpa_Ovf = 1'b0;
    chk("ovf_acc_clear", 32'(Ovf_Acumulado), 0);
    Ent_A = 6'd40; Ent_B = 6'd30; Ent_Sel = 4'b0000; Ent_Valido = 1'b1;
    tick();
    Ent_Valido = 1'b0;
    Limpa_Ovf = 1'b1;
    tick();
    Limpa_Ovf = 1'b0;
    chk("ovf_set_wins", 32'(Ovf_Acumulado), 1);
    Sai_Pronto = 1'b1;
    tick();
    Sai_Pronto = 1'b0;
    chk("ovf_contagem", 32'(Contagem), 5);

    // Zero flag: 000101 & 101010 = 0
    Ent_A = 6'd5; Ent_B = 6'd42; Ent_Sel = 4'b1000; Ent_Valido = 1'b1;
    tick();
    Ent_Valido = 1'b0;
    tick();
    chk("zero_flag", 32'(Sai_Zero), 1);
    chk("zero_sai_o", 32'(Sai_O), 0);
    chk("zero_ula_sel", 32'(ULA_Sel), 8);
    Sai_Pronto = 1'b1;
    tick();
    Sai_Pronto = 1'b0;
    chk("zero_contagem", 32'(Contagem), 6);

    // Counter wrap: 249 more ops reach 255, one more returns to 0
    for (int i = 0; i < 249; i++) run_op(6'd1, 6'd1, 4'b0000);
    chk("wrap_255", 32'(Contagem), 255);
    run_op(6'd1, 6'd1, 4'b0000);
    chk("wrap_0", 32'(Contagem), 0);
    chk("wrap_ovf_kept", 32'(Ovf_Acumulado), 1);

    // Reset during RESULTADO
    run_op(6'd2, 6'd2, 4'b0000);
    chk("mid_contagem_pre", 32'(Contagem), 1);
    Ent_A = 6'd9; Ent_B = 6'd9; Ent_Sel = 4'b0000; Ent_Valido = 1'b1;
    tick();
    Ent_Valido = 1'b0;
    tick();
    chk("mid_valido_pre", 32'(Sai_Valido), 1);
    Reset = 1'b0;
    Sai_Pronto = 1'b1;
    #1;
    chk("mid_valido", 32'(Sai_Valido), 0);
    chk("mid_sai_o", 32'(Sai_O), 0);
    chk("mid_contagem", 32'(Contagem), 0);
    chk("mid_ovf", 32'(Ovf_Acumulado), 0);
    chk("mid_ula_a", 32'(ULA_A), 0);
    chk("mid_ula_reset", 32'(ULA_Reset), 1);
    chk("mid_ent_pronto", 32'(Ent_Pronto), 0);
    tick();
    chk("mid_hold_valido", 32'(Sai_Valido), 0);
    Reset = 1'b1;
    Sai_Pronto = 1'b0;
    tick();
    chk("mid_rel_pronto", 32'(Ent_Pronto), 1);
    chk("mid_rel_contagem", 32'(Contagem), 0);
    chk("mid_rel_valido", 32'(Sai_Valido), 0);
    chk("mid_rel_ula_reset", 32'(ULA_Reset), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
